pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV32IM pipeline.
- Drives the write-enable and flush inputs of the PC register, the IF/ID register and the ID/EX register.
- Resolves three hazard classes: load-use data hazards, taken-branch/jump redirects, and multi-cycle DIV/REM occupancy of EX.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/hazard_sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control logic.
// Holds the FSM encoding, the canonical NOP and the register-index width.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
// Holds at all-ones once reached.
module hazard_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch redirects and multi-cycle divide occupancy of EX.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [REG_IDX_W-1:0] ID_RS1,
  input  logic [REG_IDX_W-1:0] ID_RS2,
  input  logic                 ID_USES_RS1,
  input  logic                 ID_USES_RS2,
  input  logic [REG_IDX_W-1:0] EX_RD,
  input  logic                 EX_MEM_READ,
  input  logic                 EX_DIV,
  input  logic                 EX_BRANCH_TAKEN,
  output logic                 PC_WRITE,
  output logic                 IF_ID_WRITE,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_WRITE,
  output logic                 ID_EX_FLUSH,
  output logic                 PC_SEL_BRANCH,
  output logic                 DIV_BUSY,
  output logic [CNT_W-1:0]     STALL_COUNT
);

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

  hazard_state_e state, state_next;
  logic [7:0]    div_cnt, div_cnt_next;
  logic          load_use;

  // Register x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = EX_MEM_READ && (EX_RD != '0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= RUN;
      div_cnt <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    div_cnt_next  = div_cnt;
    PC_WRITE      = 1'b1;
    IF_ID_WRITE   = 1'b1;
    ID_EX_WRITE   = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    PC_SEL_BRANCH = 1'b0;
    DIV_BUSY      = 1'b0;

    unique case (state)
      RUN: begin
        // A branch alongside EX_DIV is a malformed decode; the redirect wins.
        if (EX_BRANCH_TAKEN) begin
          PC_SEL_BRANCH = 1'b1;
          IF_ID_FLUSH   = 1'b1;
          ID_EX_FLUSH   = 1'b1;
        end else if (EX_DIV) begin
          PC_WRITE     = 1'b0;
          IF_ID_WRITE  = 1'b0;
          ID_EX_WRITE  = 1'b0;
          state_next   = DIV_WAIT;
          div_cnt_next = DIV_LOAD;
        end else if (load_use) begin
          PC_WRITE    = 1'b0;
          IF_ID_WRITE = 1'b0;
          ID_EX_FLUSH = 1'b1;
        end
      end
      DIV_WAIT: begin
        DIV_BUSY    = 1'b1;
        PC_WRITE    = 1'b0;
        IF_ID_WRITE = 1'b0;
        ID_EX_WRITE = 1'b0;
        if (div_cnt == '0) begin
          state_next = RUN;
        end else begin
          div_cnt_next = div_cnt - 8'd1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase

    if (RESET) begin
      PC_WRITE      = 1'b0;
      IF_ID_WRITE   = 1'b0;
      ID_EX_WRITE   = 1'b0;
      IF_ID_FLUSH   = 1'b1;
      ID_EX_FLUSH   = 1'b1;
      PC_SEL_BRANCH = 1'b0;
      DIV_BUSY      = 1'b0;
    end
  end

  hazard_sat_counter #(
    .W(CNT_W)
  ) u_stall_counter (
    .clk  (CLK),
    .reset(RESET),
    .en   (!PC_WRITE),
    .count(STALL_COUNT)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl; a second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_div, ex_branch_taken;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        pc_sel_branch, div_busy;
  logic [31:0] stall_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush;
  logic        s_pc_sel_branch, s_div_busy;
  logic [3:0]  s_stall_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(32)) dut (
    .CLK(clk), .RESET(reset),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .EX_DIV(ex_div), .EX_BRANCH_TAKEN(ex_branch_taken),
    .PC_WRITE(pc_write), .IF_ID_WRITE(if_id_write), .IF_ID_FLUSH(if_id_flush),
    .ID_EX_WRITE(id_ex_write), .ID_EX_FLUSH(id_ex_flush), .PC_SEL_BRANCH(pc_sel_branch),
    .DIV_BUSY(div_busy), .STALL_COUNT(stall_count)
  );

  pipeline_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(4)) dut_sat (
    .CLK(clk), .RESET(reset),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .EX_DIV(ex_div), .EX_BRANCH_TAKEN(ex_branch_taken),
    .PC_WRITE(s_pc_write), .IF_ID_WRITE(s_if_id_write), .IF_ID_FLUSH(s_if_id_flush),
    .ID_EX_WRITE(s_id_ex_write), .ID_EX_FLUSH(s_id_ex_flush), .PC_SEL_BRANCH(s_pc_sel_branch),
    .DIV_BUSY(s_div_busy), .STALL_COUNT(s_stall_count)
  );

  // Expected outputs packed as {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, pc_sel, busy}
  localparam logic [6:0] E_RST  = 7'b0010100;
  localparam logic [6:0] E_NORM = 7'b1101000;
  localparam logic [6:0] E_LU   = 7'b0001100;
  localparam logic [6:0] E_BR   = 7'b1111110;
  localparam logic [6:0] E_DIV  = 7'b0000000;
  localparam logic [6:0] E_WAIT = 7'b0000001;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       dv;
    logic       br;
    logic [6:0] exp;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tab [NVEC];

  function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic mr, logic dv, logic br, logic [6:0] exp);
    mk = '{rst, rs1, rs2, u1, u2, rd, mr, dv, br, exp};
  endfunction

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; ex_rd = v.rd;
    ex_mem_read = v.mr; ex_div = v.dv; ex_branch_taken = v.br;
    #1;
  endtask

  task automatic check_output(input string name, input logic [6:0] exp, input logic rst);
    logic [6:0] act;
    logic [6:0] act_s;
    int exp_sat;
    act   = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, pc_sel_branch, div_busy};
    act_s = {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_pc_sel_branch, s_div_busy};
    exp_sat = (exp_count > 15) ? 15 : exp_count;
    checks++;
    if (act !== exp || act_s !== exp) begin
      errors++;
      $display("[TB] FAIL %s ctrl: got %b / %b, want %b", name, act, act_s, exp);
    end
    checks++;
    if (stall_count !== 32'(exp_count)) begin
      errors++;
      $display("[TB] FAIL %s stall_count: got %0d, want %0d", name, stall_count, exp_count);
    end
    checks++;
    if (s_stall_count !== 4'(exp_sat)) begin
      errors++;
      $display("[TB] FAIL %s sat_count: got %0d, want %0d", name, s_stall_count, exp_sat);
    end
    // The counter model advances on the edge that follows this sample.
    if (rst) exp_count = 0;
    else if (!exp[6]) exp_count++;
  endtask

  initial begin
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_div = 1'b0; ex_branch_taken = 1'b0;

    //            rst  rs1   rs2   u1 u2 rd    mr dv br exp
    tab[0]  = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, E_RST);
    tab[1]  = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, E_RST);
    tab[2]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, E_DIV);
    tab[3]  = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_RST);
    tab[4]  = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_RST);
    tab[5]  = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_RST);
    tab[6]  = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_NORM);
    tab[7]  = mk(0, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0, E_LU);
    tab[8]  = mk(0, 5'd1, 5'd5, 1, 1, 5'd5, 0, 0, 0, E_NORM);
    tab[9]  = mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, E_NORM);
    tab[10] = mk(0, 5'd9, 5'd2, 0, 1, 5'd9, 1, 0, 0, E_NORM);
    tab[11] = mk(0, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 1, E_BR);
    tab[12] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, E_BR);
    tab[13] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_NORM);
    tab[14] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, E_DIV);
    tab[15] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_WAIT);
    tab[16] = mk(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, E_WAIT);
    tab[17] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_WAIT);
    tab[18] = mk(0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, E_LU);
    tab[19] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_NORM);
    tab[20] = mk(0, 5'd31, 5'd4, 1, 0, 5'd31, 1, 0, 0, E_LU);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(tab[i]);
      check_output($sformatf("vec%0d", i), tab[i].exp, tab[i].rst);
    end

    // Sustained load-use stall drives the 4-bit counter past its ceiling.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(mk(0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 0, E_LU));
      check_output($sformatf("sat%0d", i), E_LU, 1'b0);
    end
    apply_stimulus(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_NORM));
    check_output("sat_final", E_NORM, 1'b0);

    // Divide followed immediately by a dependent load on exit.
    apply_stimulus(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_RST));
    check_output("b2b_rst", E_RST, 1'b1);
    apply_stimulus(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, E_DIV));
    check_output("b2b_div", E_DIV, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_WAIT));
      check_output($sformatf("b2b_wait%0d", i), E_WAIT, 1'b0);
    end
    apply_stimulus(mk(0, 5'd0, 5'd8, 0, 1, 5'd8, 1, 0, 0, E_LU));
    check_output("b2b_lu", E_LU, 1'b0);
    apply_stimulus(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E_NORM));
    check_output("b2b_done", E_NORM, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
